// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL control blocks (phase stepper, lock sync).
package pll_ctrl_pkg;

    localparam int PLL_NUM_CH      = 5;
    localparam int PLL_SEL_W       = 3;

    localparam int DEF_STEP_W      = 8;
    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_PULSE_CYC   = 2;
    localparam int DEF_GAP_CYC     = 2;
    localparam int DEF_LOCK_WAIT   = 16;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STEP_LO,
        ST_STEP_HI,
        ST_LOAD,
        ST_WAIT_LOCK,
        ST_DONE
    } step_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_phase_stepper_if.sv
// Request/status channel between the CSR logic and the PLL phase stepper.
interface pll_phase_stepper_if
    import pll_ctrl_pkg::*;
#(
    parameter int STEP_W = DEF_STEP_W
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic [PLL_SEL_W-1:0] req_sel;
    logic                 req_dir;
    logic [STEP_W-1:0]    req_steps;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output req_valid, req_sel, req_dir, req_steps,
        input  req_ready, busy, done, err
    );

    modport slave (
        input  req_valid, req_sel, req_dir, req_steps,
        output req_ready, busy, done, err
    );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser plus consecutive-high debounce for the raw PLL lock.
module pll_lock_sync
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_in,
    output logic lock_stable
);

    localparam int CNT_W = $clog2(LOCK_WAIT + 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_stable_q, lock_stable_d;

    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    always_comb begin
        meta_d = lock_in;
        sync_d = meta_q;
        cnt_d  = cnt_q;
        if (!sync_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(LOCK_WAIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        lock_stable_d = (cnt_d == CNT_W'(LOCK_WAIT));
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q        <= 1'b0;
            sync_q        <= 1'b0;
            cnt_q         <= '0;
            lock_stable_q <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            lock_stable_q <= lock_stable_d;
        end
    end

    assign lock_stable = lock_stable_q;

endmodule

// File: rtl/pll_phase_stepper.sv
// Drives the PLL dynamic phase port for one shift request, then waits for re-lock.
// Optional WAIT_LOCK timeout is enabled by defining PLL_PHASE_TIMEOUT_EN.
module pll_phase_stepper
    import pll_ctrl_pkg::*;
#(
    parameter int STEP_W      = DEF_STEP_W,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int PULSE_CYC   = DEF_PULSE_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int LOCK_WAIT   = DEF_LOCK_WAIT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    pll_phase_stepper_if.slave   req_if,
    input  logic                 pll_lock_in,
    output logic                 lock_stable,
    output logic [PLL_SEL_W-1:0] phase_sel,
    output logic                 phase_dir,
    output logic                 phase_step_n,
    output logic                 load_phase
);

    localparam int TMR_W = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || GAP_CYC < 1 || LOCK_WAIT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("pll_phase_stepper: timing parameters must all be >= 1");
    end

    step_state_e          state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [STEP_W-1:0]    steps_q, steps_d;
    logic [PLL_SEL_W-1:0] sel_q, sel_d;
    logic                 dir_q, dir_d;
    logic                 err_flag_q, err_flag_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 step_n_q, step_n_d;
    logic                 load_q, load_d;
    logic                 accept;
    logic                 bad_sel;
    logic                 timeout_hit;

    pll_lock_sync #(.LOCK_WAIT(LOCK_WAIT)) u_lock_sync (
        .clk         (clk),
        .rst         (rst),
        .lock_in     (pll_lock_in),
        .lock_stable (lock_stable)
    );

`ifdef PLL_PHASE_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = (state_q == ST_WAIT_LOCK) ? wait_cnt_q + WAIT_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end

    assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign accept  = req_if.req_valid && req_ready_q;
    assign bad_sel = (req_if.req_sel >= PLL_SEL_W'(PLL_NUM_CH));

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        steps_d    = steps_q;
        sel_d      = sel_q;
        dir_d      = dir_q;
        err_flag_d = err_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_flag_d = bad_sel;
                    tmr_d      = '0;
                    // Rejected and empty requests never touch the PLL pins.
                    if (bad_sel || req_if.req_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d   = req_if.req_sel;
                        dir_d   = req_if.req_dir;
                        steps_d = req_if.req_steps;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_q == TMR_W'(SETUP_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_STEP_LO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_STEP_LO: begin
                if (tmr_q == TMR_W'(PULSE_CYC - 1)) begin
                    tmr_d   = '0;
                    steps_d = steps_q - STEP_W'(1);
                    state_d = ST_STEP_HI;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_STEP_HI: begin
                if (tmr_q == TMR_W'(GAP_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = (steps_q != '0) ? ST_STEP_LO : ST_LOAD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_LOAD:      state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_stable) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        // Outputs are registered off the current state, so pins trail state_q by one cycle.
        req_ready_d = (state_q == ST_IDLE) && !accept;
        busy_d      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_d      = (state_q == ST_DONE);
        err_d       = (state_q == ST_DONE) && err_flag_q;
        step_n_d    = (state_q != ST_STEP_LO);
        load_d      = (state_q == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            steps_q     <= '0;
            sel_q       <= '0;
            dir_q       <= 1'b0;
            err_flag_q  <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            step_n_q    <= 1'b1;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            steps_q     <= steps_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            err_flag_q  <= err_flag_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            step_n_q    <= step_n_d;
            load_q      <= load_d;
        end
    end

    assign req_if.req_ready = req_ready_q;
    assign req_if.busy      = busy_q;
    assign req_if.done      = done_q;
    assign req_if.err       = err_q;
    assign phase_sel        = sel_q;
    assign phase_dir        = dir_q;
    assign phase_step_n     = step_n_q;
    assign load_phase       = load_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: vector table plus reset, lock-drop, timeout and mid-op reset sequences.
module tb_pll_phase_stepper;
    import pll_ctrl_pkg::*;

    localparam int STEP_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock_in;
    logic       lock_stable;
    logic [2:0] phase_sel;
    logic       phase_dir;
    logic       phase_step_n;
    logic       load_phase;

    pll_phase_stepper_if #(.STEP_W(STEP_W)) req_if ();

    pll_phase_stepper #(
        .STEP_W      (STEP_W),
        .SETUP_CYC   (1),
        .PULSE_CYC   (2),
        .GAP_CYC     (2),
        .LOCK_WAIT   (16),
        .TIMEOUT_CYC (4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (req_if),
        .pll_lock_in  (pll_lock_in),
        .lock_stable  (lock_stable),
        .phase_sel    (phase_sel),
        .phase_dir    (phase_dir),
        .phase_step_n (phase_step_n),
        .load_phase   (load_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       dir;
        logic [7:0] steps;
        int         exp_first_lo;
        int         exp_load;
        int         exp_done;
        logic       exp_err;
        int         exp_pulses;
        int         exp_busy;
        logic [2:0] exp_sel;
        logic       exp_dir;
    } vec_t;

    vec_t vecs [8];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one request at a negedge; returns at the negedge after the accept edge A.
    task automatic send_req(input logic [2:0] sel, input logic dir, input logic [7:0] steps);
        req_if.req_valid = 1'b1;
        req_if.req_sel   = sel;
        req_if.req_dir   = dir;
        req_if.req_steps = steps;
        tick();
        req_if.req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   first_lo, load_k, done_k, pulses, busy_cnt, wave_err;
        logic err_at, ready_at, prev_n, exp_n;
        logic [2:0] sel_at;
        logic dir_at;

        //                sel   dir   steps  1stLo load  done  err   pul  busy esel  edir
        vecs[0] = '{3'd2, 1'b1, 8'd3,   2,    14,   16,   1'b0, 3,   15,  3'd2, 1'b1};
        vecs[1] = '{3'd0, 1'b0, 8'd1,   2,    6,    8,    1'b0, 1,   7,   3'd0, 1'b0};
        vecs[2] = '{3'd4, 1'b1, 8'd2,   2,    10,   12,   1'b0, 2,   11,  3'd4, 1'b1};
        vecs[3] = '{3'd3, 1'b0, 8'd0,   -1,   -1,   1,    1'b0, 0,   0,   3'd4, 1'b1};
        vecs[4] = '{3'd6, 1'b0, 8'd5,   -1,   -1,   1,    1'b1, 0,   0,   3'd4, 1'b1};
        vecs[5] = '{3'd5, 1'b0, 8'd1,   -1,   -1,   1,    1'b1, 0,   0,   3'd4, 1'b1};
        vecs[6] = '{3'd7, 1'b1, 8'd0,   -1,   -1,   1,    1'b1, 0,   0,   3'd4, 1'b1};
        vecs[7] = '{3'd1, 1'b0, 8'd255, 2,    1022, 1024, 1'b0, 255, 1023, 3'd1, 1'b0};

        rst              = 1'b1;
        pll_lock_in      = 1'b1;
        req_if.req_valid = 1'b0;
        req_if.req_sel   = '0;
        req_if.req_dir   = 1'b0;
        req_if.req_steps = '0;

        // Reset values and lock acquisition after release.
        repeat (4) tick();
        check("rst_req_ready",    req_if.req_ready, 0);
        check("rst_busy",         req_if.busy,      0);
        check("rst_done",         req_if.done,      0);
        check("rst_err",          req_if.err,       0);
        check("rst_lock_stable",  lock_stable,      0);
        check("rst_phase_sel",    phase_sel,        0);
        check("rst_phase_dir",    phase_dir,        0);
        check("rst_phase_step_n", phase_step_n,     1);
        check("rst_load_phase",   load_phase,       0);
        rst = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1)  check("ready_after_rst", req_if.req_ready, 1);
            if (k == 17) check("lock_stable_k17", lock_stable, 0);
            if (k == 18) check("lock_stable_k18", lock_stable, 1);
        end

        // Table-driven requests with lock held.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d_ready_pre", i), req_if.req_ready, 1);
            send_req(vecs[i].sel, vecs[i].dir, vecs[i].steps);
            check($sformatf("v%0d_ready_A", i), req_if.req_ready, 0);
            first_lo = -1; load_k = -1; done_k = -1;
            pulses = 0; busy_cnt = 0; wave_err = 0; prev_n = 1'b1;
            err_at = 1'b0; ready_at = 1'b0; sel_at = '0; dir_at = 1'b0;
            for (int k = 1; k <= 1200 && done_k < 0; k++) begin
                tick();
                exp_n = !(vecs[i].exp_pulses > 0 && k >= vecs[i].exp_first_lo &&
                          k < vecs[i].exp_first_lo + 4 * vecs[i].exp_pulses &&
                          ((k - vecs[i].exp_first_lo) % 4) < 2);
                if (phase_step_n !== exp_n) wave_err++;
                if (load_phase !== (k == vecs[i].exp_load)) wave_err++;
                if (!phase_step_n && first_lo < 0) first_lo = k;
                if (!phase_step_n && prev_n) pulses++;
                prev_n = phase_step_n;
                if (load_phase && load_k < 0) load_k = k;
                if (req_if.busy) busy_cnt++;
                if (req_if.done) begin
                    done_k   = k;
                    err_at   = req_if.err;
                    ready_at = req_if.req_ready;
                    sel_at   = phase_sel;
                    dir_at   = phase_dir;
                end else if (req_if.err) begin
                    wave_err++;
                end
            end
            check($sformatf("v%0d_first_lo", i),   first_lo, vecs[i].exp_first_lo);
            check($sformatf("v%0d_load", i),       load_k,   vecs[i].exp_load);
            check($sformatf("v%0d_done", i),       done_k,   vecs[i].exp_done);
            check($sformatf("v%0d_err", i),        err_at,   vecs[i].exp_err);
            check($sformatf("v%0d_pulses", i),     pulses,   vecs[i].exp_pulses);
            check($sformatf("v%0d_busy_cyc", i),   busy_cnt, vecs[i].exp_busy);
            check($sformatf("v%0d_wave_err", i),   wave_err, 0);
            check($sformatf("v%0d_sel", i),        sel_at,   vecs[i].exp_sel);
            check($sformatf("v%0d_dir", i),        dir_at,   vecs[i].exp_dir);
            check($sformatf("v%0d_ready_done", i), ready_at, 0);
            tick();
            check($sformatf("v%0d_ready_post", i), req_if.req_ready, 1);
        end

        // Lock lost during the last step, restored 10 cycles later: stepping continues, done waits for a fresh run.
        send_req(3'd2, 1'b1, 8'd3);
        load_k = -1; done_k = -1;
        for (int k = 1; k <= 200 && done_k < 0; k++) begin
            tick();
            if (k == 10) pll_lock_in = 1'b0;
            if (k == 13) check("drop_lock_lost", lock_stable, 0);
            if (k == 20) pll_lock_in = 1'b1;
            if (load_phase && load_k < 0) load_k = k;
            if (req_if.done) done_k = k;
        end
        check("drop_load", load_k, 14);
        check("drop_done", done_k, 40);
        tick();

`ifdef PLL_PHASE_TIMEOUT_EN
        // Lock held low: WAIT_LOCK gives up after 4096 cycles with err.
        pll_lock_in = 1'b0;
        repeat (5) tick();
        send_req(3'd0, 1'b0, 8'd1);
        done_k = -1; err_at = 1'b0;
        for (int k = 1; k <= 4300 && done_k < 0; k++) begin
            tick();
            if (req_if.done) begin
                done_k = k;
                err_at = req_if.err;
            end
        end
        check("tmo_done", done_k, 4103);
        check("tmo_err",  err_at, 1);
        pll_lock_in = 1'b1;
        repeat (20) tick();
`endif

        // Reset during the second low pulse.
        check("midrst_ready_pre", req_if.req_ready, 1);
        send_req(3'd3, 1'b1, 8'd4);
        repeat (6) tick();
        check("midrst_second_lo", phase_step_n, 0);
        rst = 1'b1;
        tick();
        check("midrst_step_n",  phase_step_n,     1);
        check("midrst_busy",    req_if.busy,      0);
        check("midrst_done",    req_if.done,      0);
        check("midrst_ready",   req_if.req_ready, 0);
        check("midrst_sel",     phase_sel,        0);
        check("midrst_load",    load_phase,       0);
        rst = 1'b0;
        tick();
        check("midrst_ready_rel", req_if.req_ready, 1);
        wave_err = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req_if.done || !phase_step_n || load_phase || req_if.busy) wave_err++;
        end
        check("midrst_quiet", wave_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
